// File: rtl/costas_sync_pkg.sv
// Shared types, widths and helpers for the Costas sync reference qualifier.
package costas_sync_pkg;

  // Width of the period, pulse, holdoff and lock counters.
  localparam int unsigned CNT_W     = 32;
  // One extra bit so period arithmetic can go negative without wrapping.
  localparam int unsigned CNT_W_EXT = CNT_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StPulse,
    StHoldoff
  } state_e;

  // True when |meas - period| <= tol, evaluated in signed arithmetic.
  function automatic logic in_tol(input logic [CNT_W-1:0] meas,
                                  input logic [CNT_W-1:0] period,
                                  input logic [CNT_W-1:0] tol);
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] lim;
    diff = $signed({1'b0, meas}) - $signed({1'b0, period});
    lim  = $signed({1'b0, tol});
    return (diff <= lim) && (diff >= -lim);
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Synchroniser chain plus run-length glitch filter with a registered rising-edge strobe.
module sync_glitch_filter
  import costas_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic clockin,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FCW-1:0]         fcnt_q;
  logic                   level_q;
  logic                   level_prev_q;
  logic                   rise_q;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];
  assign level  = level_q;
  assign rise   = rise_q;

  // Shift the asynchronous input through the synchroniser flops.
  always_ff @(posedge clockin or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Level follows the sample only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clockin or negedge rstn) begin
    if (!rstn) begin
      fcnt_q  <= '0;
      level_q <= 1'b0;
    end else if (sample == level_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
      fcnt_q  <= '0;
      level_q <= sample;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  // One-cycle strobe, one cycle after the filtered level goes 0 -> 1.
  always_ff @(posedge clockin or negedge rstn) begin
    if (!rstn) begin
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

endmodule

// File: rtl/costas_sync_qualifier.sv
// Qualifies the external sync reference and drives the divider's active-low sync pulse.
module costas_sync_qualifier
  import costas_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned PULSE_WIDTH = 2,
  parameter int unsigned HOLDOFF     = 500,
  parameter int unsigned PERIOD      = 1001,
  parameter int unsigned TOL         = 4,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic clockin,
  input  logic rstn,
  input  logic enable,
  input  logic sync_raw,
  output logic sync,
  output logic locked,
  output logic missed
);

  localparam logic [CNT_W:0] TIMEOUT_VAL =
    CNT_W_EXT'(PERIOD) + CNT_W_EXT'(TOL) + CNT_W_EXT'(1);

  logic level;
  logic rise;

  sync_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clockin(clockin),
    .rstn   (rstn),
    .din    (sync_raw),
    .level  (level),
    .rise   (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic             first_q, first_d;
  logic             sync_q, sync_d;
  logic             locked_q, locked_d;
  logic             missed_q, missed_d;
  logic             run_q;
  logic             accept;
  logic             timeout_hit;
  logic             idle_now;

  assign sync   = sync_q;
  assign locked = locked_q;
  assign missed = missed_q;

  // Hold the FSM for one edge after reset release so it moves on the second edge.
  always_ff @(posedge clockin or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Edge acceptance, timeout, FSM, measurement and output next-state.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    per_d    = per_q;
    good_d   = good_q;
    first_d  = first_q;

    idle_now    = (state_q == StIdle) || !enable;
    accept      = (state_q == StArmed) && enable && rise && level;
    // An edge landing on the timeout cycle takes precedence over the miss.
    timeout_hit = !idle_now && !first_q && ({1'b0, per_q} == TIMEOUT_VAL);
    missed_d    = timeout_hit && !accept;

    unique case (state_q)
      StIdle: begin
        if (enable && run_q) state_d = StArmed;
      end
      StArmed: begin
        if (accept) begin
          state_d = StPulse;
          pcnt_d  = CNT_W'(1);
        end
      end
      StPulse: begin
        if (pcnt_q >= PULSE_WIDTH) begin
          state_d = StHoldoff;
          hcnt_d  = CNT_W'(1);
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        if (hcnt_q >= HOLDOFF) begin
          state_d = StArmed;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) state_d = StIdle;

    if (idle_now) begin
      per_d   = '0;
      good_d  = '0;
      first_d = 1'b1;
    end else if (accept) begin
      per_d   = CNT_W'(1);
      first_d = 1'b0;
      if (!first_q) begin
        if (in_tol(per_q, CNT_W'(PERIOD), CNT_W'(TOL))) begin
          good_d = (good_q < LOCK_COUNT) ? good_q + 1'b1 : good_q;
        end else begin
          good_d = '0;
        end
      end
    end else begin
      if (per_q != '1) per_d = per_q + 1'b1;
      if (timeout_hit) good_d = '0;
    end

    sync_d   = (state_d != StPulse);
    locked_d = enable && (good_q == LOCK_COUNT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clockin or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      per_q    <= '0;
      good_q   <= '0;
      first_q  <= 1'b1;
      sync_q   <= 1'b1;
      locked_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      per_q    <= per_d;
      good_q   <= good_d;
      first_q  <= first_d;
      sync_q   <= sync_d;
      locked_q <= locked_d;
      missed_q <= missed_d;
    end
  end

endmodule
